dekatron_counter_sequencer: RTL and testbench

- Sequences a chain of DIGITS one-hot, 10-position dekatron digits as a single multi-digit decimal counter.
- Accepts increment/decrement requests and pulses the digits one at a time, least significant first. Each digit step takes PULSE_CYCLES clocks.
- Evaluates the digit's carry (9->0 on increment) or borrow (0->9 on decrement), then ripples to the next digit.
- Sits between the instruction/address control logic and the dekatron register banks (IP, AP, loop counters).

---
 rtl/dekatron_counter_sequencer.sv | 113 +++++++++++
 tb/tb_dekatron_counter_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dekatron_counter_sequencer.sv
// Multi-digit decimal counter built from one-hot dekatron digits; carries and
// borrows ripple LSD-first, one digit step per PULSE_CYCLES-wide drive pulse.

module dekatronDigit (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       clear,
  input  logic       step,
  input  logic       dec,
  output logic [9:0] pos
);
  // Rotating the one-hot vector keeps the field one-hot by construction.
  always_ff @(posedge Clk) begin
    if (Rst || clear) pos <= 10'd1;
    else if (step)    pos <= dec ? {pos[0], pos[9:1]} : {pos[8:0], pos[9]};
  end
endmodule

module dekatron_counter_sequencer #(
  parameter int DIGITS       = 6,
  parameter int PULSE_CYCLES = 2
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Request,
  input  logic                Dec,
  input  logic                Zero,
  output logic                Ready,
  output logic                Busy,
  output logic [DIGITS*10-1:0] Out,
  output logic                Overflow
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam logic [IW-1:0] LAST      = IW'(DIGITS - 1);
  localparam logic [PW-1:0] PULSE_END = PW'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, STEP, CHECK} seqState_t;

  seqState_t state, stateNext;
  logic [IW-1:0] idx;
  logic [PW-1:0] pulseCnt;
  logic          decLat;
  logic          accept, clear, stepNow, ripple, pulseLast;
  logic [DIGITS-1:0][9:0] digitPos;
  logic [9:0]    curDigit;

  assign Out       = digitPos;
  assign Ready     = (state == IDLE);
  assign Busy      = ~Ready;
  assign pulseLast = (pulseCnt == PULSE_END);
  assign curDigit  = digitPos[idx];
  // Carry on landing at 0 going up, borrow on landing at 9 going down.
  assign ripple    = decLat ? curDigit[9] : curDigit[0];

  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    clear     = 1'b0;
    stepNow   = 1'b0;
    case (state)
      IDLE: begin
        if (Zero) clear = 1'b1;
        else if (Request) begin
          accept    = 1'b1;
          stateNext = STEP;
        end
      end
      STEP: begin
        if (pulseLast) begin
          stepNow   = 1'b1;
          stateNext = CHECK;
        end
      end
      CHECK:   stateNext = (ripple && idx != LAST) ? STEP : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      idx      <= '0;
      pulseCnt <= '0;
      decLat   <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      state <= stateNext;
      if (clear) Overflow <= 1'b0;
      if (accept) begin
        decLat   <= Dec;
        idx      <= '0;
        pulseCnt <= '0;
      end
      if (state == STEP) pulseCnt <= pulseLast ? '0 : pulseCnt + 1'b1;
      if (state == CHECK && ripple) begin
        if (idx == LAST) Overflow <= 1'b1;
        else             idx      <= idx + 1'b1;
      end
    end
  end

  for (genvar d = 0; d < DIGITS; d++) begin : gDigit
    dekatronDigit uDigit (
      .Clk   (Clk),
      .Rst   (Rst),
      .clear (clear),
      .step  (stepNow && (idx == IW'(d))),
      .dec   (decLat),
      .pos   (digitPos[d])
    );
  end
endmodule

// File: tb/tb_dekatron_counter_sequencer.sv
// Bench for dekatron_counter_sequencer: decimal-digit reference model with a
// per-cycle timeline of when each rippled digit becomes visible.

module tb_dekatron_counter_sequencer;
  localparam int D = 6;
  localparam int P = 2;

  logic Clk = 1'b0, Rst = 1'b0, Request = 1'b0, Dec = 1'b0, Zero = 1'b0;
  logic Ready, Busy, Overflow;
  logic [D*10-1:0] Out;

  int errors = 0, checks = 0;
  int dig[D];
  bit ovf = 1'b0;
  bit ohEnable = 1'b0;

  dekatron_counter_sequencer #(.DIGITS(D), .PULSE_CYCLES(P)) dut (
    .Clk(Clk), .Rst(Rst), .Request(Request), .Dec(Dec), .Zero(Zero),
    .Ready(Ready), .Busy(Busy), .Out(Out), .Overflow(Overflow)
  );

  always #5 Clk = ~Clk;

  function automatic logic [D*10-1:0] mk(input int v[D]);
    logic [D*10-1:0] e;
    e = '0;
    for (int j = 0; j < D; j++) e[j*10 + v[j]] = 1'b1;
    return e;
  endfunction

  // Every digit field must be one-hot in every cycle once out of reset.
  always @(negedge Clk) begin
    if (ohEnable) begin
      for (int j = 0; j < D; j++) begin
        checks++;
        if ($countones(Out[j*10 +: 10]) != 1) begin
          errors++;
          $display("FAIL onehot digit%0d got=%b", j, Out[j*10 +: 10]);
        end
      end
    end
  end

  task automatic checkIdle(input string name);
    checks++;
    if (Ready !== 1'b1 || Busy !== 1'b0 || Out !== mk(dig) || Overflow !== ovf) begin
      errors++;
      $display("FAIL %s got rdy=%b busy=%b ovf=%b out=%h exp rdy=1 busy=0 ovf=%b out=%h",
               name, Ready, Busy, Overflow, Out, ovf, mk(dig));
    end
  endtask

  // One count operation. Assumes we are at a negedge in IDLE.
  task automatic doOp(input bit dec, input bit keepReq, input bit noise, input string name);
    int old[D];
    int expd[D];
    int nd, total, nv;
    bit wrap, expOvf, expRdy;
    old = dig; nd = 0; wrap = 0;
    for (int j = 0; j < D; j++) begin
      nv = dec ? (old[j] + 9) % 10 : (old[j] + 1) % 10;
      nd++;
      dig[j] = nv;
      if (nv != (dec ? 9 : 0)) break;
      if (j == D - 1) wrap = 1;
    end
    total = nd * (P + 1);
    Request = 1'b1; Dec = dec; Zero = 1'b0;
    @(posedge Clk);
    for (int t = 1; t <= total + 1; t++) begin
      @(negedge Clk);
      for (int j = 0; j < D; j++)
        expd[j] = (j < nd && t >= j * (P + 1) + P + 1) ? dig[j] : old[j];
      expOvf = ovf | (wrap && t == total + 1);
      expRdy = (t > total);
      checks++;
      if (Ready !== expRdy || Busy !== !expRdy || Out !== mk(expd) || Overflow !== expOvf) begin
        errors++;
        $display("FAIL %s t=%0d got rdy=%b busy=%b ovf=%b out=%h exp rdy=%b ovf=%b out=%h",
                 name, t, Ready, Busy, Overflow, Out, expRdy, expOvf, mk(expd));
      end
      if (t <= total) begin
        if (noise) begin
          Request = 1'($urandom); Dec = 1'($urandom); Zero = 1'($urandom);
        end else Request = 1'b0;
      end else begin
        Request = keepReq; Zero = 1'b0;
      end
    end
    ovf = ovf | wrap;
  endtask

  task automatic doZero(input bit withReq, input string name);
    Zero = 1'b1; Request = withReq; Dec = 1'($urandom);
    @(posedge Clk);
    @(negedge Clk);
    Zero = 1'b0; Request = 1'b0;
    for (int j = 0; j < D; j++) dig[j] = 0;
    ovf = 1'b0;
    checkIdle(name);
    @(negedge Clk);
    checkIdle({name, "_hold"});
  endtask

  task automatic test_reset();
    Rst = 1'b1; Request = 1'b0; Zero = 1'b0; Dec = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    for (int j = 0; j < D; j++) dig[j] = 0;
    ovf = 1'b0;
    ohEnable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk);
      checkIdle("reset_idle");
    end
  endtask

  task automatic test_single_inc();
    doOp(1'b0, 1'b0, 1'b0, "single_inc");
  endtask

  task automatic test_ripple();
    doZero(1'b0, "ripple_zero");
    for (int i = 0; i < 999; i++) doOp(1'b0, i < 998, 1'b0, "preload999");
    doOp(1'b0, 1'b0, 1'b0, "ripple_1000");
    checks++;
    if (Out !== mk('{0, 0, 0, 1, 0, 0})) begin
      errors++;
      $display("FAIL ripple_final got=%h exp=%h", Out, mk('{0, 0, 0, 1, 0, 0}));
    end
  endtask

  task automatic test_borrow_overflow();
    test_reset();
    doOp(1'b1, 1'b0, 1'b0, "borrow_wrap");
    checks++;
    if (Overflow !== 1'b1 || Out !== mk('{9, 9, 9, 9, 9, 9})) begin
      errors++;
      $display("FAIL borrow_all9 got ovf=%b out=%h exp ovf=1", Overflow, Out);
    end
    doOp(1'b1, 1'b0, 1'b0, "ovf_sticky");
    doZero(1'b0, "zero_clears_ovf");
  endtask

  task automatic test_priority_ignore();
    doOp(1'b0, 1'b0, 1'b0, "pre_priority");
    doZero(1'b1, "zero_beats_request");
    doOp(1'b0, 1'b0, 1'b1, "ignore_busy");
    checks++;
    if (Out !== mk('{1, 0, 0, 0, 0, 0})) begin
      errors++;
      $display("FAIL ignore_count got=%h exp=%h", Out, mk('{1, 0, 0, 0, 0, 0}));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) doOp(1'($urandom), i < 11, 1'b0, "back_to_back");
  endtask

  task automatic test_reset_mid();
    doZero(1'b0, "mid_zero");
    for (int i = 0; i < 99; i++) doOp(1'b0, i < 98, 1'b0, "preload99");
    Request = 1'b1; Dec = 1'b0;
    @(posedge Clk);
    repeat (4) @(negedge Clk);
    Request = 1'b0;
    Rst = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    for (int j = 0; j < D; j++) dig[j] = 0;
    ovf = 1'b0;
    checkIdle("reset_mid");
    doOp(1'b0, 1'b0, 1'b0, "after_reset_inc");
    checks++;
    if (Out !== mk('{1, 0, 0, 0, 0, 0})) begin
      errors++;
      $display("FAIL after_reset_count got=%h exp=%h", Out, mk('{1, 0, 0, 0, 0, 0}));
    end
  endtask

  task automatic test_random();
    bit lastKeep;
    lastKeep = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!lastKeep && $urandom_range(0, 19) == 0) doZero(1'($urandom), "rand_zero");
      else begin
        lastKeep = 1'($urandom);
        doOp(1'($urandom), lastKeep, 1'($urandom), "rand_op");
      end
    end
    if (lastKeep) begin
      Request = 1'b0;
      doOp(1'b0, 1'b0, 1'b0, "rand_tail");
    end
  endtask

  initial begin
    @(negedge Clk);
    test_reset();
    test_single_inc();
    test_ripple();
    test_borrow_overflow();
    test_priority_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    @(negedge Clk);
    ohEnable = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
